// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core: machine word, icache FSM state
// and a per-way cache line template.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Line template sized for the default geometry (8 sets x 2 words).
    localparam int ICACHE_DEF_WORDS = 2;
    localparam int ICACHE_DEF_TAG_W = 26;

    typedef struct packed {
        logic                                valid;
        logic [ICACHE_DEF_TAG_W-1:0]         tag;
        word_t [ICACHE_DEF_WORDS-1:0]        data;
    } icache_line_t;

endpackage

// File: rtl/param_icache_way.sv
// One way of the instruction cache: valid bits, tag store and block data,
// with a combinational lookup port and a single fill/maintenance write port.
module icache_way
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WORDS = 2,
    parameter int IDX_W = 3,
    parameter int OFF_W = 1,
    parameter int TAG_W = 26
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic             rd_match,
    output word_t            rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  word_t            wr_data,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             set_valid,
    input  logic             clr_valid,
    input  logic             clr_all
);

    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem [SETS];
    word_t data_mem [SETS][WORDS];

    // clr_all dominates so an invalidate racing a fill completion wins.
    always_comb begin
        valid_d = valid_q;
        if (clr_valid) valid_d[wr_index] = 1'b0;
        if (set_valid) valid_d[wr_index] = 1'b1;
        if (clr_all)   valid_d = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    always_ff @(posedge CLK) begin
        if (set_valid) tag_mem[wr_index] <= wr_tag;
        if (wr_en)     data_mem[wr_index][wr_offset] <= wr_data;
    end

    always_comb begin
        rd_valid = valid_q[rd_index];
        rd_match = rd_valid && (tag_mem[rd_index] == rd_tag);
        rd_data  = data_mem[rd_index][rd_offset];
    end

endmodule

// File: rtl/param_icache.sv
// Parametrised instruction cache (1 or 2 ways) with multi-word block fill,
// per-set LRU replacement and whole-cache synchronous invalidate.
module param_icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WORDS = 2,
    parameter int WAYS  = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inv,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);

    localparam int OFF_BITS  = $clog2(WORDS);
    localparam int IDX_W     = $clog2(SETS);
    localparam int OFF_W     = (OFF_BITS == 0) ? 1 : OFF_BITS;
    localparam int TAG_W     = 30 - OFF_BITS - IDX_W;
    localparam int BLK_BYTES = 4 * WORDS;

    icache_state_t state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [31:0]      base_q, base_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             victim_q, victim_d;
    logic [SETS-1:0]  lru_q, lru_d;

    logic [31:0]      word_addr;
    logic [OFF_W-1:0] req_offset;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      req_base;

    logic [WAYS-1:0]  way_valid;
    logic [WAYS-1:0]  way_match;
    word_t            way_data [WAYS];

    logic             any_match, hit, hit_way, victim_sel;
    logic             miss_start, accept, last_word, fill_we, fill_done;
    logic [IDX_W-1:0] wr_index;

    always_comb begin
        word_addr  = {2'b00, imemaddr[31:2]};
        req_offset = OFF_W'(word_addr & 32'(WORDS - 1));
        req_index  = IDX_W'(word_addr >> OFF_BITS);
        req_tag    = TAG_W'(word_addr >> (OFF_BITS + IDX_W));
        req_base   = imemaddr & ~32'(BLK_BYTES - 1);
    end

    // Invalidation of the victim happens in IDLE at the miss; fill writes
    // in FILL use the latched index.
    assign wr_index = (state_q == FILL) ? index_q : req_index;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            icache_way #(
                .SETS (SETS),
                .WORDS(WORDS),
                .IDX_W(IDX_W),
                .OFF_W(OFF_W),
                .TAG_W(TAG_W)
            ) u_way (
                .CLK      (CLK),
                .nRST     (nRST),
                .rd_index (req_index),
                .rd_offset(req_offset),
                .rd_tag   (req_tag),
                .rd_valid (way_valid[gi]),
                .rd_match (way_match[gi]),
                .rd_data  (way_data[gi]),
                .wr_en    (fill_we && (victim_q == 1'(gi))),
                .wr_index (wr_index),
                .wr_offset(cnt_q),
                .wr_data  (iload),
                .wr_tag   (tag_q),
                .set_valid(fill_done && (victim_q == 1'(gi))),
                .clr_valid(miss_start && (victim_sel == 1'(gi))),
                .clr_all  (inv)
            );
        end
    endgenerate

    always_comb begin
        any_match  = |way_match;
        hit        = (state_q == IDLE) && imemREN && !inv && any_match;
        hit_way    = (WAYS == 2) && way_match[WAYS-1];
        miss_start = (state_q == IDLE) && imemREN && !inv && !any_match;
        accept     = (state_q == FILL) && !iwait;
        last_word  = (cnt_q == OFF_W'(WORDS - 1));
        fill_we    = accept && !inv;
        fill_done  = fill_we && last_word;
    end

    // Prefer an empty way; only evict by LRU when the set is full.
    always_comb begin
        victim_sel = 1'b0;
        if (WAYS == 2) begin
            if (!way_valid[0])           victim_sel = 1'b0;
            else if (!way_valid[WAYS-1]) victim_sel = 1'b1;
            else                         victim_sel = lru_q[req_index];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (miss_start) state_d = FILL;
            FILL: if (inv || fill_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iREN     = (state_q == FILL);
        iaddr    = iREN ? (base_q + (32'(cnt_q) << 2)) : 32'h0;
        ihit     = hit;
        imemload = hit ? way_data[hit_way] : 32'h0;
    end

    always_comb begin
        cnt_d    = cnt_q;
        base_d   = base_q;
        index_d  = index_q;
        tag_d    = tag_q;
        victim_d = victim_q;
        if (miss_start) begin
            cnt_d    = '0;
            base_d   = req_base;
            index_d  = req_index;
            tag_d    = req_tag;
            victim_d = victim_sel;
        end else if (state_q == FILL) begin
            if (inv || fill_done) cnt_d = '0;
            else if (fill_we)     cnt_d = cnt_q + 1'b1;
        end
    end

    // LRU bit names the way NOT most recently touched.
    always_comb begin
        lru_d = lru_q;
        if (inv) begin
            lru_d = '0;
        end else if (WAYS == 2) begin
            if (hit)       lru_d[req_index] = ~hit_way;
            if (fill_done) lru_d[index_q]   = ~victim_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q    <= '0;
            base_q   <= '0;
            index_q  <= '0;
            tag_q    <= '0;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            index_q  <= index_d;
            tag_q    <= tag_d;
            victim_q <= victim_d;
            lru_q    <= lru_d;
        end
    end

endmodule

// File: tb/tb_param_icache.sv
// Directed bench for param_icache (8 sets, 2 words, 2 ways) with a
// two-cycle-per-word memory model driven from the stimulus sequence.
module tb_param_icache;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit;
    logic [31:0] imemload;
    logic        inv = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload = 32'h0;
    logic        iwait = 1'b1;

    int checks = 0;
    int failures = 0;
    int lat_cnt = 0;

    param_icache #(.SETS(8), .WORDS(2), .WAYS(2)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .imemREN (imemREN),
        .imemaddr(imemaddr),
        .ihit    (ihit),
        .imemload(imemload),
        .inv     (inv),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iload   (iload),
        .iwait   (iwait)
    );

    always #5 CLK = ~CLK;

    // Memory image: 0x40 -> AAAA0001, 0x44 -> AAAA0002, 0x80 -> AAAA0011, ...
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA0000 + ((a - 32'h3C) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic pr, pw;
        pr = iREN;
        pw = iwait;
        @(posedge CLK);
        if (pr && !pw) lat_cnt = 0;
        else if (pr)   lat_cnt++;
        #1;
        if (iREN) begin
            iwait = (lat_cnt < LAT - 1);
            iload = mem_word(iaddr);
        end else begin
            iwait   = 1'b1;
            lat_cnt = 0;
            iload   = 32'h0;
        end
        #1;
    endtask

    task automatic fill_wait(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (!iREN) break;
            step();
        end
        chk(tag, {31'h0, iREN}, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a);
        imemREN  = 1'b1;
        imemaddr = a;
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_iren", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_load", imemload, 32'h0);
        step();
        nRST = 1'b1;
        step();

        // Cold miss on 0x40: fill 0x40/0x44, hit after 5 cycles
        fetch(32'h40);
        chk("t1_miss", {31'h0, ihit}, 32'h0);
        step();
        chk("t1_iren", {31'h0, iREN}, 32'h1);
        chk("t1_iaddr0", iaddr, 32'h40);
        chk("t1_nohit_fill", {31'h0, ihit}, 32'h0);
        step();
        chk("t1_iaddr0_hold", iaddr, 32'h40);
        step();
        chk("t1_iaddr1", iaddr, 32'h44);
        step();
        chk("t1_nohit_fill2", {31'h0, ihit}, 32'h0);
        step();
        chk("t1_ren_done", {31'h0, iREN}, 32'h0);
        chk("t1_hit", {31'h0, ihit}, 32'h1);
        chk("t1_load", imemload, 32'hAAAA0001);
        step();
        fetch(32'h44);
        chk("t1_hit44", {31'h0, ihit}, 32'h1);
        chk("t1_load44", imemload, 32'hAAAA0002);
        step();

        // LRU: 0x80 into way 1, touch 0x40, 0xC0 evicts 0x80
        fetch(32'h80);
        chk("t2_miss80", {31'h0, ihit}, 32'h0);
        step();
        chk("t2_iaddr80", iaddr, 32'h80);
        fill_wait("t2_fill80");
        chk("t2_hit80", imemload, 32'hAAAA0011);
        step();
        fetch(32'h40);
        chk("t2_hit40", imemload, 32'hAAAA0001);
        step();
        fetch(32'hC0);
        chk("t2_missC0", {31'h0, ihit}, 32'h0);
        step();
        fill_wait("t2_fillC0");
        chk("t2_hitC4", {31'h0, ihit}, 32'h1);
        fetch(32'hC4);
        chk("t2_loadC4", imemload, 32'hAAAA0022);
        step();
        fetch(32'h40);
        chk("t2_rehit40", imemload, 32'hAAAA0001);
        step();
        fetch(32'h80);
        chk("t2_evicted80", {31'h0, ihit}, 32'h0);
        step();
        chk("t2_refill80", iaddr, 32'h80);
        fill_wait("t2_fill80b");
        step();

        // Invalidate pulse in IDLE
        fetch(32'h40);
        chk("t3_prehit", {31'h0, ihit}, 32'h1);
        inv = 1'b1;
        #1;
        chk("t3_inv_forces0", {31'h0, ihit}, 32'h0);
        step();
        inv = 1'b0;
        #1;
        chk("t3_miss_after_inv", {31'h0, ihit}, 32'h0);
        step();
        chk("t3_refill_iren", {31'h0, iREN}, 32'h1);
        chk("t3_refill_addr", iaddr, 32'h40);

        // Invalidate during FILL at cnt=1
        step();
        step();
        chk("t4_cnt1", iaddr, 32'h44);
        inv = 1'b1;
        step();
        inv = 1'b0;
        #1;
        chk("t4_abort_iren", {31'h0, iREN}, 32'h0);
        chk("t4_still_miss", {31'h0, ihit}, 32'h0);

        // Request changes mid-fill; fill for 0x40 still completes
        step();
        chk("t5_iaddr", iaddr, 32'h40);
        step();
        imemREN  = 1'b0;
        imemaddr = 32'h200;
        #1;
        fill_wait("t5_fill");
        chk("t5_idle_nohit", {31'h0, ihit}, 32'h0);
        chk("t5_idle_load0", imemload, 32'h0);
        step();
        fetch(32'h40);
        chk("t5_hit40", imemload, 32'hAAAA0001);
        fetch(32'h44);
        chk("t5_hit44", imemload, 32'hAAAA0002);
        fetch(32'h200);
        chk("t5_miss200", {31'h0, ihit}, 32'h0);

        // Asynchronous reset mid-FILL
        step();
        chk("t6_fill200", iaddr, 32'h200);
        step();
        nRST = 1'b0;
        #1;
        chk("t6_rst_iren", {31'h0, iREN}, 32'h0);
        chk("t6_rst_iaddr", iaddr, 32'h0);
        chk("t6_rst_ihit", {31'h0, ihit}, 32'h0);
        step();
        nRST = 1'b1;
        fetch(32'h40);
        chk("t6_miss40", {31'h0, ihit}, 32'h0);
        step();
        chk("t6_refill_addr", iaddr, 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_icache.md
# param_icache

Parametrised instruction cache for the pipelined MIPS core. It sits between the datapath's instruction-fetch port and the memory-controller instruction port, and supersedes the fixed direct-mapped icache. Set count, block size in words and associativity (1 or 2 ways) are configurable. Misses perform a multi-word block fill with LRU replacement, and a synchronous invalidate input clears the whole cache.

## Interface
- SETS, 8, number of sets; power of two, ≥2
- WORDS, 2, 32-bit words per block; power of two, ≥1
- WAYS, 2, associativity; 1 or 2 only
- CLK  input  1  clock; all state updates on rising edge
- nRST  input  1  asynchronous active-low reset
- imemREN  input  1  datapath fetch request
- imemaddr  input  32  byte address of the fetch; bits [1:0] ignored
- ihit  output  1  fetch data valid this cycle
- imemload  output  32  instruction word; 0 when ihit=0
- inv  input  1  invalidate all lines; sampled at the clock edge
- iREN  output  1  memory read request
- iaddr  output  32  memory word address (byte address, word aligned)
- iload  input  32  memory read data
- iwait  input  1  memory busy; data accepted in a cycle where iREN=1 and iwait=0

## Operation
- Address split: [1:0] byte, next log2(WORDS) bits block offset, next log2(SETS) bits index, remainder tag.
- Per way per set: valid, tag, WORDS data words. Per set: one LRU bit, used only when WAYS=2; it names the least-recently-used way.
- States: IDLE, FILL.
- IDLE: hit = imemREN and some valid way whose tag matches. On hit, ihit=1 combinationally, imemload = the selected word, and the LRU bit is set to the other way at the edge. On miss with imemREN=1, latch tag/index/block base, pick the victim and go to FILL.
- Victim choice: the first invalid way (way 0 before way 1); otherwise the LRU way. WAYS=1 always uses way 0.
- FILL: iREN=1, iaddr = latched block base + 4×cnt, cnt starting at 0.
  - Each cycle with iwait=0: write iload into victim word cnt, cnt+1.
  - After the word at cnt=WORDS−1: write the tag, set valid, make the victim MRU, return to IDLE.
  - The original request hits the cycle after the return to IDLE.
- Victim valid bit is cleared on FILL entry, so a partial block is never visible.
- Fill completes even if imemREN drops or imemaddr changes mid-fill.
- inv=1 in IDLE: all valid bits clear and LRU bits reset to 0 at the edge. ihit is forced to 0 in any cycle where inv=1.
- inv=1 in FILL: the fill aborts, the state returns to IDLE with no line validated, and all valid bits clear.
- Reset (async, any state): state IDLE, cnt 0, all valid/LRU bits 0, ihit 0, imemload 0, iREN 0, iaddr 0. Data/tag arrays need not be reset.

## Timing
- Hit latency: 0 cycles. ihit and imemload are combinational from imemREN/imemaddr and array state.
- Miss penalty: WORDS accepted memory words, then 1 cycle. With a memory latency of L cycles per word, total = WORDS×L + 1 cycles until ihit.
- iREN stays high continuously during FILL; iaddr changes only on the cycle after an accepted word.
- ihit is 0 throughout FILL, including when the fill word matches the request.
- The LRU update and the fill write take effect at the edge; a same-set hit in the following cycle sees the updated state.

## Structure
- cpu_types_pkg: add icache_state_t (IDLE, FILL) and a word_t-based per-way line struct template.
- Local parameters derived inside the module with $clog2.
- Natural sub-module: icache_way, holding the valid/tag/data arrays for one way. It provides a read port (index, offset, tag → match, data) and a write port (index, offset, data, tag/valid set, valid clear, clear-all). It is instantiated WAYS times.

## Test plan
- Defaults; reset; imemREN=1, imemaddr=0x40, memory L=2 returns 0xAAAA0001/0xAAAA0002 → iaddr 0x40 then 0x44, ihit after 5 cycles with 0xAAAA0001. Then 0x44 hits the next cycle with 0xAAAA0002.
- Fill 0x40, 0x80 (both index 0, ways 0/1), hit 0x40, miss 0xC0 → way 1 (holding 0x80) evicted. Re-fetch 0x40 hits; 0x80 misses.
- Fill 0x40, pulse inv for one cycle → 0x40 misses and a refill from 0x40 starts.
- Miss 0x40, assert inv while cnt=1 → iREN drops the next cycle, 0x40 still misses afterward.
- Miss 0x40, drop imemREN and change imemaddr to 0x200 mid-fill → the fill still completes for 0x40/0x44, then 0x200 misses.
- Assert nRST=0 mid-FILL → iREN=0, iaddr=0, ihit=0 immediately. After release, 0x40 misses.
